// File: rtl/rx_serial_uc.sv
// ----------------------------------------------------------------------------
// rx_serial_uc -- control unit for the UART receive datapath (rx_serial_dp).
//
// Detects the start bit and rejects short low glitches. It then steps the
// datapath through the data, optional parity and stop slots, and raises a
// one-cycle 'pronto' pulse for each received frame. It also keeps the
// data-available, parity, framing and overrun flags.
//
// Build option:
//   RX_PARITY_EN  defined   -> parity slot received (PARIDADE state),
//                              erro_paridade updated at frame end.
//                 undefined -> no parity slot; registra_parity and
//                              erro_paridade tied to 0; code 4 unused.
//
// Ports:
//   clock             system clock
//   reset             asynchronous active-low reset
//   rxd               serial line, already synchronized to clock
//   counter_half      datapath tick counter at mid-bit
//   counter_finished  datapath tick counter at last cycle of a bit slot
//   receive_finished  datapath bit counter at last data bit
//   s_parity_check    registered parity result (1 = ok)
//   recebe            consumer acknowledge, clears tem_dado
//   zera              clear datapath counters/registers
//   conta_tick        enable datapath tick counter
//   desloca           shift the sampled bit into the data shift register
//   registra_parity   load the parity-check register
//   registra_dados    load the output data register
//   pronto            one-cycle frame-done pulse
//   tem_dado          unread data held
//   erro_paridade     last frame had a parity error
//   erro_stop         last frame had a framing (stop bit) error
//   erro_overrun      last frame completed while tem_dado was still set
//   db_estado         current state code
// ----------------------------------------------------------------------------
module rx_serial_uc (
    input  logic       clock,
    input  logic       reset,
    input  logic       rxd,
    input  logic       counter_half,
    input  logic       counter_finished,
    input  logic       receive_finished,
    input  logic       s_parity_check,
    input  logic       recebe,
    output logic       zera,
    output logic       conta_tick,
    output logic       desloca,
    output logic       registra_parity,
    output logic       registra_dados,
    output logic       pronto,
    output logic       tem_dado,
    output logic       erro_paridade,
    output logic       erro_stop,
    output logic       erro_overrun,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        INICIAL  = 4'd0,
        ESPERA   = 4'd1,
        START    = 4'd2,
        DADOS    = 4'd3,
        PARIDADE = 4'd4,
        STOP     = 4'd5,
        FIM      = 4'd6
    } state_t;

    state_t state_r;
    state_t state_nxt_s;

    logic zera_s;
    logic conta_tick_s;
    logic desloca_s;
    logic registra_parity_s;
    logic registra_dados_s;
    logic pronto_s;

    logic stop_err_r;
    logic tem_dado_r;
    logic erro_stop_r;
    logic erro_overrun_r;

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= INICIAL;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic, Moore outputs and the Mealy datapath enables.
    always_comb begin
        state_nxt_s       = state_r;
        zera_s            = 1'b0;
        conta_tick_s      = 1'b0;
        desloca_s         = 1'b0;
        registra_parity_s = 1'b0;
        registra_dados_s  = 1'b0;
        pronto_s          = 1'b0;
        case (state_r)
            INICIAL: begin
                zera_s      = 1'b1;
                state_nxt_s = ESPERA;
            end
            ESPERA: begin
                zera_s = 1'b1;
                if (!rxd) begin
                    state_nxt_s = START;
                end else begin
                    state_nxt_s = ESPERA;
                end
            end
            START: begin
                conta_tick_s = 1'b1;
                // Line back high by mid-bit: it was a glitch, not a start bit.
                if (counter_half && rxd) begin
                    state_nxt_s = ESPERA;
                end else if (counter_finished) begin
                    state_nxt_s = DADOS;
                end else begin
                    state_nxt_s = START;
                end
            end
            DADOS: begin
                conta_tick_s = 1'b1;
                if (counter_finished) begin
                    desloca_s = 1'b1;
                    if (receive_finished) begin
`ifdef RX_PARITY_EN
                        state_nxt_s = PARIDADE;
`else
                        state_nxt_s = STOP;
`endif
                    end else begin
                        state_nxt_s = DADOS;
                    end
                end else begin
                    state_nxt_s = DADOS;
                end
            end
`ifdef RX_PARITY_EN
            PARIDADE: begin
                conta_tick_s = 1'b1;
                if (counter_finished) begin
                    registra_parity_s = 1'b1;
                    state_nxt_s       = STOP;
                end else begin
                    state_nxt_s = PARIDADE;
                end
            end
`endif
            STOP: begin
                conta_tick_s = 1'b1;
                // Leave at mid-bit so a start bit right after the stop bit
                // is already seen in ESPERA.
                if (counter_half) begin
                    registra_dados_s = 1'b1;
                    state_nxt_s      = FIM;
                end else begin
                    state_nxt_s = STOP;
                end
            end
            FIM: begin
                pronto_s    = 1'b1;
                state_nxt_s = ESPERA;
            end
            default: begin
                state_nxt_s = INICIAL;
            end
        endcase
    end

    // Stop-bit sample, taken at mid-bit of the stop slot.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stop_err_r <= 1'b0;
        end else if ((state_r == STOP) && counter_half) begin
            stop_err_r <= ~rxd;
        end else begin
            stop_err_r <= stop_err_r;
        end
    end

    // Frame status flags; refreshed on the FIM exit edge. A set of tem_dado
    // in FIM wins over a simultaneous consumer acknowledge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tem_dado_r     <= 1'b0;
            erro_stop_r    <= 1'b0;
            erro_overrun_r <= 1'b0;
        end else if (state_r == FIM) begin
            tem_dado_r     <= 1'b1;
            erro_stop_r    <= stop_err_r;
            erro_overrun_r <= tem_dado_r;
        end else if (recebe) begin
            tem_dado_r     <= 1'b0;
        end else begin
            tem_dado_r     <= tem_dado_r;
        end
    end

`ifdef RX_PARITY_EN
    logic erro_paridade_r;

    // Parity error flag, refreshed on the FIM exit edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            erro_paridade_r <= 1'b0;
        end else if (state_r == FIM) begin
            erro_paridade_r <= ~s_parity_check;
        end else begin
            erro_paridade_r <= erro_paridade_r;
        end
    end

    assign registra_parity = registra_parity_s;
    assign erro_paridade   = erro_paridade_r;
`else
    logic unused_s;
    assign unused_s        = s_parity_check ^ registra_parity_s;
    assign registra_parity = 1'b0;
    assign erro_paridade   = 1'b0;
`endif

    assign zera           = zera_s;
    assign conta_tick     = conta_tick_s;
    assign desloca        = desloca_s;
    assign registra_dados = registra_dados_s;
    assign pronto         = pronto_s;
    assign tem_dado       = tem_dado_r;
    assign erro_stop      = erro_stop_r;
    assign erro_overrun   = erro_overrun_r;
    assign db_estado      = state_r;

endmodule

// File: tb/tb_rx_serial_uc.sv
// ----------------------------------------------------------------------------
// tb_rx_serial_uc -- self-checking bench for rx_serial_uc.
// A small behavioural datapath (tick/bit counters, shift register, parity and
// data registers) surrounds the control unit. Expected frame results go into
// a scoreboard queue when a frame is driven. They are popped and compared
// when pronto is seen.
// ----------------------------------------------------------------------------
module tb_rx_serial_uc;

    localparam int P  = 16;   // clocks per bit
    localparam int H  = 8;    // counter_half offset within a slot
    localparam int NB = 8;
`ifdef RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int LAT = 1 + (NB + 2) * P + H + 1 - (PAR_EN ? 0 : P);

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       rxd = 1'b1;
    logic       recebe = 1'b0;
    logic       counter_half, counter_finished, receive_finished;
    logic       s_parity_check;
    logic       zera, conta_tick, desloca, registra_parity, registra_dados;
    logic       pronto, tem_dado, erro_paridade, erro_stop, erro_overrun;
    logic [3:0] db_estado;

    rx_serial_uc dut (
        .clock(clock), .reset(reset), .rxd(rxd),
        .counter_half(counter_half), .counter_finished(counter_finished),
        .receive_finished(receive_finished), .s_parity_check(s_parity_check),
        .recebe(recebe), .zera(zera), .conta_tick(conta_tick),
        .desloca(desloca), .registra_parity(registra_parity),
        .registra_dados(registra_dados), .pronto(pronto),
        .tem_dado(tem_dado), .erro_paridade(erro_paridade),
        .erro_stop(erro_stop), .erro_overrun(erro_overrun),
        .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    // Behavioural datapath model.
    logic [4:0] tick = 5'd0;
    logic [3:0] bitcnt = 4'd0;
    logic [7:0] sh = 8'd0;
    logic [7:0] dout = 8'd0;
    logic       par_ok = 1'b1;

    assign counter_half     = (tick == 5'(H));
    assign counter_finished = (tick == 5'(P - 1));
    assign receive_finished = (bitcnt == 4'(NB - 1));
    assign s_parity_check   = par_ok;

    always @(posedge clock) begin
        if (zera) begin
            tick   <= 5'd0;
            bitcnt <= 4'd0;
        end else begin
            if (conta_tick) tick <= counter_finished ? 5'd0 : tick + 5'd1;
            if (desloca) bitcnt <= bitcnt + 4'd1;
        end
        if (desloca) sh <= {rxd, sh[7:1]};
        if (registra_parity) par_ok <= ^{sh, rxd};   // odd parity: odd count of ones = ok
        if (registra_dados) dout <= sh;
    end

    typedef struct {
        logic [7:0] data;
        logic       ep;
        logic       es;
        logic       eo;
    } exp_t;

    exp_t sb_q[$];
    exp_t cur;
    logic tem_exp = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    int   n_desl = 0, n_rpar = 0, n_rdad = 0, n_pronto = 0, n_start = 0;
    bit   pend = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Line driver. The start bit is stretched by half a slot so that the
    // model's end-of-slot sampling lands mid-bit. A bad stop bit is held low
    // only across its sample point, so the line is idle again when the
    // receiver re-arms.
    task automatic send_line(input logic [7:0] d, input logic pbit, input logic stop_ok);
        rxd = 1'b0;
        cycles(P + P / 2);
        for (int i = 0; i < NB; i++) begin
            rxd = d[i];
            cycles(P);
        end
        if (PAR_EN) begin
            rxd = pbit;
            cycles(P);
        end
        if (stop_ok) begin
            rxd = 1'b1;
            cycles(P);
        end else begin
            rxd = 1'b0;
            cycles(2);
            rxd = 1'b1;
            cycles(P - 2);
        end
        cycles(8);
    endtask

    task automatic frame(input string tag, input logic [7:0] d, input logic par_good, input logic stop_ok);
        int   b_desl, b_rpar, b_rdad, b_pronto;
        logic pbit;
        exp_t e;
        b_desl = n_desl; b_rpar = n_rpar; b_rdad = n_rdad; b_pronto = n_pronto;
        pbit   = par_good ? ~^d : ^d;
        e.data = d;
        e.ep   = PAR_EN && !par_good;
        e.es   = !stop_ok;
        e.eo   = tem_exp;
        sb_q.push_back(e);
        tem_exp = 1'b1;
        send_line(d, pbit, stop_ok);
        check({tag, "_desloca"}, n_desl - b_desl, NB);
        check({tag, "_regpar"}, n_rpar - b_rpar, PAR_EN ? 1 : 0);
        check({tag, "_regdados"}, n_rdad - b_rdad, 1);
        check({tag, "_pronto"}, n_pronto - b_pronto, 1);
        check({tag, "_sb_drain"}, sb_q.size(), 0);
        check({tag, "_estado"}, db_estado, 4'd1);
    endtask

    task automatic pulse_recebe(input string tag);
        recebe = 1'b1;
        cycles(1);
        recebe = 1'b0;
        tem_exp = 1'b0;
        check({tag, "_tem_dado_clr"}, tem_dado, 1'b0);
    endtask

    // Monitor: pulse counters, latency and scoreboard comparison.
    initial begin
        forever begin
            @(negedge clock);
            cyc++;
            if (reset) begin
                n_desl   += int'(desloca);
                n_rpar   += int'(registra_parity);
                n_rdad   += int'(registra_dados);
                n_pronto += int'(pronto);
                n_start  += int'(db_estado == 4'd2);
                if (db_estado == 4'd1 && !rxd) start_cyc = cyc;
                if (pend) begin
                    pend = 1'b0;
                    check("sb_erro_paridade", erro_paridade, cur.ep);
                    check("sb_erro_stop", erro_stop, cur.es);
                    check("sb_erro_overrun", erro_overrun, cur.eo);
                    check("sb_tem_dado", tem_dado, 1'b1);
                end
                if (pronto) begin
                    check("pronto_expected", sb_q.size() != 0, 1'b1);
                    if (sb_q.size() != 0) begin
                        cur = sb_q.pop_front();
                        check("sb_latency", cyc - start_cyc, LAT);
                        check("sb_data", dout, cur.data);
                        pend = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        #200us;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  b_desl, b_pronto, b_start, b_rdad;
        bit  seen;
        cycles(3);
        check("rst_estado", db_estado, 4'd0);
        check("rst_zera", zera, 1'b1);
        check("rst_conta_tick", conta_tick, 1'b0);
        check("rst_pronto", pronto, 1'b0);
        check("rst_tem_dado", tem_dado, 1'b0);
        check("rst_erros", {erro_paridade, erro_stop, erro_overrun}, 3'b000);
        reset = 1'b1;
        cycles(4);
        check("idle_estado", db_estado, 4'd1);

        frame("f1", 8'h55, 1'b1, 1'b1);
        pulse_recebe("f1");
        frame("f2_par", 8'h55, 1'b0, 1'b1);
        pulse_recebe("f2");
        frame("f3_stop", 8'hA3, 1'b1, 1'b0);
        pulse_recebe("f3");
        frame("f4_clr", 8'h3C, 1'b1, 1'b1);

        // Low glitch shorter than half a bit.
        b_desl = n_desl; b_pronto = n_pronto; b_start = n_start; b_rdad = n_rdad;
        rxd = 1'b0;
        cycles(5);
        rxd = 1'b1;
        cycles(20);
        check("glitch_start_cycles", n_start - b_start, H + 1);
        check("glitch_desloca", n_desl - b_desl, 0);
        check("glitch_regdados", n_rdad - b_rdad, 0);
        check("glitch_pronto", n_pronto - b_pronto, 0);
        check("glitch_estado", db_estado, 4'd1);

        frame("f5_ovr", 8'h81, 1'b1, 1'b1);
        pulse_recebe("f5");

        // Acknowledge coinciding with FIM: the set wins.
        seen = 1'b0;
        fork
            frame("f6_ack", 8'h7E, 1'b1, 1'b1);
            begin
                for (int i = 0; i < 400; i++) begin
                    @(negedge clock);
                    if (db_estado == 4'd6) begin
                        seen = 1'b1;
                        break;
                    end
                end
                if (seen) begin
                    recebe = 1'b1;
                    @(posedge clock);
                    #1;
                    recebe = 1'b0;
                end
            end
        join
        check("f6_fim_seen", seen, 1'b1);
        check("f6_tem_dado_kept", tem_dado, 1'b1);

        // Reset in the middle of a frame.
        seen = 1'b0;
        b_pronto = n_pronto;
        fork
            send_line(8'h55, 1'b1, 1'b1);
            begin
                for (int i = 0; i < 400; i++) begin
                    @(negedge clock);
                    if (db_estado == 4'd3) begin
                        seen = 1'b1;
                        break;
                    end
                end
                reset = 1'b0;
                #1;
                check("mid_rst_seen_dados", seen, 1'b1);
                check("mid_rst_estado", db_estado, 4'd0);
                check("mid_rst_zera", zera, 1'b1);
                check("mid_rst_conta_tick", conta_tick, 1'b0);
                check("mid_rst_tem_dado", tem_dado, 1'b0);
                check("mid_rst_erros", {erro_paridade, erro_stop, erro_overrun}, 3'b000);
            end
        join
        check("mid_rst_no_pronto", n_pronto - b_pronto, 0);
        reset = 1'b1;
        tem_exp = 1'b0;
        cycles(4);
        check("post_rst_estado", db_estado, 4'd1);

        frame("f7_post", 8'h55, 1'b1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
